// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared FSM state type and width for the TRNG harvester
package trng_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2,
        ST_FAULT   = 2'd3
    } trng_state_e;

endpackage

// File: rtl/trng_rct.sv
// rtl/trng_rct.sv - repetition-count health test on the sampled entropy bit
module trng_rct
    import trng_pkg::*;
#(
    parameter int RCT_CUTOFF = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_bit,
    input  logic i_clear,
    output logic o_trip
);

    logic       r_last_bit;
    logic [7:0] r_cnt;

    // A zero count marks "no reference bit yet", so the next tick always loads 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_bit <= 1'b0;
            r_cnt      <= 8'd0;
        end else if (i_clear) begin
            r_cnt <= 8'd0;
        end else if (i_tick) begin
            r_last_bit <= i_bit;
            if ((r_cnt != 8'd0) && (i_bit == r_last_bit)) begin
                if (r_cnt != 8'hFF) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                r_cnt <= 8'd1;
            end
        end
    end

    assign o_trip = (r_cnt == 8'(RCT_CUTOFF));

endmodule

// File: rtl/trng_harvester.sv
// rtl/trng_harvester.sv - multi-channel TRNG harvester; Von Neumann corrector under TRNG_VN_DEBIAS_EN
module trng_harvester
    import trng_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int DIV_W      = 8,
    parameter int RCT_CUTOFF = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] raw_bits,
    input  logic                enable,
    input  logic [CHANNELS-1:0] chan_mask,
    input  logic [DIV_W-1:0]    sample_div,
    input  logic                clear_fail,
    output logic [WIDTH-1:0]    data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                health_fail
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [DIV_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_bitcnt;
    logic [WIDTH-1:0]    r_shreg;
    logic [WIDTH-1:0]    r_data_out;
    logic                r_data_valid;
    logic                r_health_fail;
    trng_state_e         r_state;
    trng_state_e         w_state_nxt;

    logic w_comb_bit;
    logic w_tick;
    logic w_trip;
    logic w_rct_clear;
    logic w_bit_ok;
    logic w_bit_in;
    logic w_accept;
    logic w_load;
    logic w_clr_fail;

    // Two-flop synchroniser per asynchronous entropy channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_bits;
            r_sync2 <= r_sync1;
        end
    end

    assign w_comb_bit  = ^(r_sync2 & chan_mask);
    assign w_tick      = enable && (r_state != ST_FAULT) && (r_div == sample_div);
    // Holding the RCT cleared while disabled makes the first tick after enable rise load 1.
    assign w_rct_clear = clear_fail | ~enable;

    // Sample-rate divider, parked at zero while disabled or faulted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (!enable || (r_state == ST_FAULT) || (r_div == sample_div)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    trng_rct #(
        .RCT_CUTOFF(RCT_CUTOFF)
    ) u_rct (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_tick (w_tick),
        .i_bit  (w_comb_bit),
        .i_clear(w_rct_clear),
        .o_trip (w_trip)
    );

`ifdef TRNG_VN_DEBIAS_EN
    logic r_vn_first;
    logic r_vn_phase;

    // Pair up collected ticks; the first bit of a 01/10 pair is the corrected output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vn_first <= 1'b0;
            r_vn_phase <= 1'b0;
        end else if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FAULT)) begin
            r_vn_phase <= 1'b0;
        end else if ((r_state == ST_COLLECT) && w_tick) begin
            r_vn_phase <= ~r_vn_phase;
            if (!r_vn_phase) begin
                r_vn_first <= w_comb_bit;
            end
        end
    end

    assign w_bit_ok = w_tick && r_vn_phase && (r_vn_first != w_comb_bit);
    assign w_bit_in = r_vn_first;
`else
    assign w_bit_ok = w_tick;
    assign w_bit_in = w_comb_bit;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes; priority is disable, then RCT trip, then normal flow.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_clr_fail  = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else if (w_trip && (r_state != ST_FAULT)) begin
            w_state_nxt = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_COLLECT;
                ST_COLLECT: begin
                    if (w_bit_ok) begin
                        w_accept = 1'b1;
                        if (r_bitcnt == CNT_W'(WIDTH - 1)) begin
                            w_state_nxt = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (!r_data_valid || data_ready) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_COLLECT;
                    end
                end
                ST_FAULT: begin
                    if (clear_fail) begin
                        w_clr_fail  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Bit collection, word hand-off and sticky health flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bitcnt      <= '0;
            r_shreg       <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_health_fail <= 1'b0;
        end else begin
            if (w_load || (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FAULT)) begin
                r_bitcnt <= '0;
            end else if (w_accept) begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
            end

            if (w_state_nxt == ST_FAULT) begin
                r_shreg <= '0;
            end else if (w_accept) begin
                r_shreg <= {r_shreg[WIDTH-2:0], w_bit_in};
            end

            if (w_load) begin
                r_data_out   <= r_shreg;
                r_data_valid <= 1'b1;
            end else if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end

            if ((w_state_nxt == ST_FAULT) && (r_state != ST_FAULT)) begin
                r_health_fail <= 1'b1;
            end else if (w_clr_fail) begin
                r_health_fail <= 1'b0;
            end
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign health_fail = r_health_fail;

endmodule
